sprite_palette_scheduler: RTL and testbench

//  Shares one 16-entry sprite palette lookup (4-bit index -> 4/4/4 RGB, combinational) between two fighter sprite layers and
//  the stage background, once per pixel. Resolves layering and transparency, and sequences per-player hit-flash.

---
 rtl/sprite_palette_scheduler.sv | 173 +++++++++++++++++
 tb/tb_sprite_palette_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_scheduler.sv
// sprite_palette_scheduler
//   Shares one 16-entry sprite palette between two fighter layers and the
//   stage background, one pixel per clock. Stage 1 resolves layering and
//   transparency and drives the palette index. Stage 2 picks the final colour
//   from background, palette or hit-flash colour.
//   Each player has a flash FSM (IDLE/ON/OFF) stepped by frame_start pulses.
// Ports
//   Clk, Reset           pixel clock, asynchronous active-high reset
//   frame_start          one-cycle pulse at the first pixel of a frame
//   pix_valid            current pixel is in the active area
//   p1_index, p2_index   sprite palette indices for the current pixel
//   p1_hit, p2_hit       one-cycle pulses: player was struck
//   front_sel            requested top layer (0 = P1, 1 = P2)
//   bg_rgb               background colour for the current pixel
//   pal_index / pal_rgb  shared combinational palette lookup
//   rgb, rgb_valid       final pixel colour, two clocks after the inputs
module sprite_palette_scheduler #(
  parameter logic [3:0]  TRANSP_INDEX = 4'h0,
  parameter int          FLASH_FRAMES = 16,
  parameter int          BLINK_FRAMES = 2,
  parameter logic [11:0] FLASH_RGB    = 12'hFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [3:0]  p1_index,
  input  logic [3:0]  p2_index,
  input  logic        p1_hit,
  input  logic        p2_hit,
  input  logic        front_sel,
  input  logic [11:0] bg_rgb,
  output logic [3:0]  pal_index,
  input  logic [11:0] pal_rgb,
  output logic [11:0] rgb,
  output logic        rgb_valid
);

  localparam logic [7:0] FLASH_N = 8'(FLASH_FRAMES);
  localparam logic [7:0] BLINK_N = 8'(BLINK_FRAMES);

  localparam logic [1:0] SRC_BG = 2'd0;
  localparam logic [1:0] SRC_P1 = 2'd1;
  localparam logic [1:0] SRC_P2 = 2'd2;

  typedef enum logic [1:0] {IDLE, ON, OFF} flash_t;

  flash_t     fstate   [2];
  flash_t     fstate_n [2];
  logic [7:0] fcnt     [2];
  logic [7:0] fcnt_n   [2];
  logic [7:0] bcnt     [2];
  logic [7:0] bcnt_n   [2];
  logic [1:0] hit;

  logic       front_q;
  logic       front_eff;
  logic [3:0] front_idx;
  logic [3:0] back_idx;
  logic [3:0] win_idx;
  logic [1:0] win_src;

  logic [1:0]  src_p1;
  logic [11:0] bg_p1;
  logic        vld_p1;
  logic        flash_on;

  assign hit = {p2_hit, p1_hit};

  // Flash FSMs: a hit always restarts at ON with fresh counters, and swallows
  // a coincident frame_start. fcnt counts frames since the hit, bcnt counts
  // frames within the current ON/OFF phase.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        fstate[i] <= IDLE;
        fcnt[i]   <= 8'd0;
        bcnt[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fstate[i] <= fstate_n[i];
        fcnt[i]   <= fcnt_n[i];
        bcnt[i]   <= bcnt_n[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fstate_n[i] = fstate[i];
      fcnt_n[i]   = fcnt[i];
      bcnt_n[i]   = bcnt[i];
      if (hit[i]) begin
        fstate_n[i] = ON;
        fcnt_n[i]   = 8'd0;
        bcnt_n[i]   = 8'd0;
      end else if (frame_start && fstate[i] != IDLE) begin
        if (fcnt[i] + 8'd1 == FLASH_N) begin
          fstate_n[i] = IDLE;
          fcnt_n[i]   = 8'd0;
          bcnt_n[i]   = 8'd0;
        end else begin
          fcnt_n[i] = fcnt[i] + 8'd1;
          if (bcnt[i] + 8'd1 == BLINK_N) begin
            bcnt_n[i]   = 8'd0;
            fstate_n[i] = (fstate[i] == ON) ? OFF : ON;
          end else begin
            bcnt_n[i] = bcnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Layer order is latched at frame_start; the frame_start pixel itself
  // already uses the newly requested order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      front_q <= 1'b0;
    end else if (frame_start) begin
      front_q <= front_sel;
    end
  end

  always_comb begin
    front_eff = frame_start ? front_sel : front_q;
    front_idx = front_eff ? p2_index : p1_index;
    back_idx  = front_eff ? p1_index : p2_index;
    win_idx   = TRANSP_INDEX;
    win_src   = SRC_BG;
    if (front_idx != TRANSP_INDEX) begin
      win_idx = front_idx;
      win_src = front_eff ? SRC_P2 : SRC_P1;
    end else if (back_idx != TRANSP_INDEX) begin
      win_idx = back_idx;
      win_src = front_eff ? SRC_P1 : SRC_P2;
    end
  end

  // ---- stage 1: winner index to palette, tag and background registered ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pal_index <= TRANSP_INDEX;
      src_p1    <= SRC_BG;
      bg_p1     <= 12'd0;
      vld_p1    <= 1'b0;
    end else begin
      pal_index <= win_idx;
      src_p1    <= win_src;
      bg_p1     <= bg_rgb;
      vld_p1    <= pix_valid;
    end
  end

  assign flash_on = ((src_p1 == SRC_P1) && (fstate[0] == ON)) ||
                    ((src_p1 == SRC_P2) && (fstate[1] == ON));

  // ---- stage 2: final colour select ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb       <= 12'd0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= vld_p1;
      if (!vld_p1)                rgb <= 12'd0;
      else if (src_p1 == SRC_BG)  rgb <= bg_p1;
      else if (flash_on)          rgb <= FLASH_RGB;
      else                        rgb <= pal_rgb;
    end
  end

endmodule

// File: tb/tb_sprite_palette_scheduler.sv
module tb_sprite_palette_scheduler;

  localparam int FF_A = 4;
  localparam int BF_A = 1;
  localparam int FF_B = 7;
  localparam int BF_B = 2;
  localparam int NEVER = 1000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  p1_index = 4'd0;
  logic [3:0]  p2_index = 4'd0;
  logic        p1_hit = 1'b0;
  logic        p2_hit = 1'b0;
  logic        front_sel = 1'b0;
  logic [11:0] bg_rgb = 12'd0;
  logic [3:0]  pal_index_a, pal_index_b;
  logic [11:0] pal_rgb_a, pal_rgb_b, rgb_a, rgb_b;
  logic        rgb_valid_a, rgb_valid_b;

  logic [11:0] palette [16];

  assign pal_rgb_a = palette[pal_index_a];
  assign pal_rgb_b = palette[pal_index_b];

  sprite_palette_scheduler #(.TRANSP_INDEX(4'h0), .FLASH_FRAMES(FF_A),
    .BLINK_FRAMES(BF_A), .FLASH_RGB(12'hFFF)) u_a (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .p1_index(p1_index), .p2_index(p2_index), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .front_sel(front_sel), .bg_rgb(bg_rgb), .pal_index(pal_index_a),
    .pal_rgb(pal_rgb_a), .rgb(rgb_a), .rgb_valid(rgb_valid_a));

  sprite_palette_scheduler #(.TRANSP_INDEX(4'h0), .FLASH_FRAMES(FF_B),
    .BLINK_FRAMES(BF_B), .FLASH_RGB(12'hFFF)) u_b (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .p1_index(p1_index), .p2_index(p2_index), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .front_sel(front_sel), .bg_rgb(bg_rgb), .pal_index(pal_index_b),
    .pal_rgb(pal_rgb_b), .rgb(rgb_b), .rgb_valid(rgb_valid_b));

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames elapsed since each player's last hit, plus the
  // front layer latched for the current frame.
  typedef struct {
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    logic        vld;
    logic [3:0]  pal;
  } exp_t;

  int   since [2];
  bit   front_m;
  exp_t q[$];
  bit   allow_hits;

  function automatic bit flashing(int p, int ff, int bf);
    return (since[p] < ff) && (((since[p] / bf) % 2) == 0);
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [3:0] idx [2];
    int f, b, w;
    idx[0] = p1_index;
    idx[1] = p2_index;
    f = (frame_start ? front_sel : front_m) ? 1 : 0;
    b = 1 - f;
    if (idx[f] != 4'd0)      w = f;
    else if (idx[b] != 4'd0) w = b;
    else                     w = -1;
    e.pal = (w < 0) ? 4'd0 : idx[w];
    e.vld = pix_valid;
    if (!pix_valid) begin
      e.rgb_a = 12'd0;
      e.rgb_b = 12'd0;
    end else if (w < 0) begin
      e.rgb_a = bg_rgb;
      e.rgb_b = bg_rgb;
    end else begin
      e.rgb_a = flashing(w, FF_A, BF_A) ? 12'hFFF : palette[idx[w]];
      e.rgb_b = flashing(w, FF_B, BF_B) ? 12'hFFF : palette[idx[w]];
    end
    return e;
  endfunction

  task automatic model_reset();
    since[0] = NEVER;
    since[1] = NEVER;
    front_m = 1'b0;
    q.delete();
    q.push_back('{rgb_a: 12'd0, rgb_b: 12'd0, vld: 1'b0, pal: 4'd0});
  endtask

  task automatic step();
    exp_t e, x;
    logic [1:0] h;
    e = model();
    q.push_back(e);
    h = {p2_hit, p1_hit};
    if (frame_start) front_m = front_sel;
    for (int p = 0; p < 2; p++) begin
      if (h[p]) since[p] = 0;
      else if (frame_start && since[p] < NEVER) since[p]++;
    end
    @(posedge Clk);
    #1;
    check("pal_index_a", pal_index_a, e.pal);
    check("pal_index_b", pal_index_b, e.pal);
    if (q.size() >= 2) begin
      x = q.pop_front();
      check("rgb_a", rgb_a, x.rgb_a);
      check("rgb_b", rgb_b, x.rgb_b);
      check("rgb_valid_a", rgb_valid_a, x.vld);
      check("rgb_valid_b", rgb_valid_b, x.vld);
    end
  endtask

  function automatic logic [3:0] rand_idx();
    return ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
  endfunction

  task automatic set_in(bit fs, bit pv, bit h1, bit h2);
    frame_start = fs;
    pix_valid   = pv;
    p1_hit      = h1;
    p2_hit      = h2;
    p1_index    = rand_idx();
    p2_index    = rand_idx();
    front_sel   = 1'($urandom_range(1));
    bg_rgb      = 12'($urandom);
  endtask

  task automatic reset_pulse(int n);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_in(1'($urandom_range(1)), 1'($urandom_range(1)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      #1;
      check("rst_rgb", rgb_a, 12'd0);
      check("rst_vld", rgb_valid_b, 1'b0);
      check("rst_pal", pal_index_a, 4'd0);
      @(posedge Clk);
      #1;
    end
    model_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
  endtask

  task automatic hit_bit(output bit h);
    h = allow_hits && ($urandom_range(3) == 0);
  endtask

  // Hits only arrive on frame_start or well after the last active pixel, so
  // every active pixel of a frame sees one stable flash state.
  task automatic run_frame(int npix);
    bit h1, h2;
    hit_bit(h1);
    hit_bit(h2);
    set_in(1'b1, 1'b0, h1, h2);
    step();
    for (int i = 0; i < npix; i++) begin
      set_in(1'b0, ($urandom_range(7) != 0), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      h1 = 0;
      h2 = 0;
      if (i == 2) begin
        hit_bit(h1);
        hit_bit(h2);
      end
      set_in(1'b0, 1'b0, h1, h2);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) palette[i] = 12'($urandom);
    palette[3] = 12'hA0A;
    allow_hits = 1'b1;
    #2;
    reset_pulse(4);

    // Directed layering right after reset release (front = P1 from reset).
    pix_valid = 1'b1; p1_index = 4'd3; p2_index = 4'd5; bg_rgb = 12'h777;
    step();
    p1_index = 4'd0;
    step();
    p2_index = 4'd0; bg_rgb = 12'h123;
    step();
    pix_valid = 1'b0;
    step();
    step();

    for (int f = 0; f < 30; f++) run_frame(6);

    // Reset in the middle of a frame (and most likely mid-flash).
    p1_hit = 1'b1;
    step();
    p1_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    reset_pulse(2);
    allow_hits = 1'b0;
    for (int f = 0; f < 4; f++) run_frame(5);
    allow_hits = 1'b1;
    for (int f = 0; f < 20; f++) run_frame(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
